// File: rtl/agc_pipa_pkg.sv
// agc_pipa_pkg: shared axis/state types, PIPA counter addresses and arbitration helpers
package agc_pipa_pkg;
    typedef enum logic [1:0] {AX_X, AX_Y, AX_Z} axis_t;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;
    localparam logic [11:0] ADR_PIPAX = 12'o0037;
    localparam logic [11:0] ADR_PIPAY = 12'o0040;
    localparam logic [11:0] ADR_PIPAZ = 12'o0041;
    function automatic axis_t nxt_axis(input axis_t a);
        return a == AX_X ? AX_Y : a == AX_Y ? AX_Z : AX_X;
    endfunction
    function automatic logic [11:0] axis_adr(input axis_t a);
        return a == AX_X ? ADR_PIPAX : a == AX_Y ? ADR_PIPAY : ADR_PIPAZ;
    endfunction
endpackage

// File: rtl/pipa_axis_acc.sv
// pipa_axis_acc: per-axis signed pending-increment accumulator with saturation and fail detect
module pipa_axis_acc #(
    parameter int PW = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sam,
    input  logic i_p,
    input  logic i_m,
    input  logic i_ack_p,
    input  logic i_ack_m,
    output logic o_pend_nz,
    output logic o_pend_neg,
    output logic o_ovf_evt,
    output logic o_fail_evt
);
    localparam logic signed [PW+1:0] ONE  = 1;
    localparam logic signed [PW+1:0] LIM  = (PW+2)'(2**(PW-1)-1);
    localparam logic signed [PW+1:0] NLIM = -LIM;
    logic signed [PW-1:0] r_pend;
    logic signed [PW+1:0] w_ext, w_net, w_ackt, w_sum;
    logic w_hi, w_lo;
    assign w_ext  = {{2{r_pend[PW-1]}}, r_pend};
    assign w_net  = (i_sam & i_p & ~i_m) ? ONE : (i_sam & i_m & ~i_p) ? -ONE : '0;
    // an acked PINC consumes one positive pending pulse, an acked MINC one negative
    assign w_ackt = i_ack_p ? ONE : i_ack_m ? -ONE : '0;
    assign w_sum  = w_ext + w_net - w_ackt;
    assign w_hi   = w_sum > LIM;
    assign w_lo   = w_sum < NLIM;
    assign o_pend_nz  = r_pend != '0;
    assign o_pend_neg = r_pend[PW-1];
    assign o_ovf_evt  = w_hi | w_lo;
    assign o_fail_evt = i_sam & i_p & i_m;
    always_ff @(posedge clk) begin
        if (rst)
            r_pend <= '0;
        else
            r_pend <= w_hi ? LIM[PW-1:0] : w_lo ? NLIM[PW-1:0] : w_sum[PW-1:0];
    end
endmodule

// File: rtl/pipa_incr_sched.sv
// pipa_incr_sched: round-robin scheduler turning PIPA pulses into PINC/MINC counter requests
import agc_pipa_pkg::*;
module pipa_incr_sched #(
    parameter int PW = 4
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        PIPSAM,
    input  logic        PIPAXp,
    input  logic        PIPAXm,
    input  logic        PIPAYp,
    input  logic        PIPAYm,
    input  logic        PIPAZp,
    input  logic        PIPAZm,
    input  logic        CTRACK,
    input  logic        CLRFLG,
    output logic        CTRREQ,
    output logic [11:0] CTRADR,
    output logic        CTRMINC,
    output logic        PIPOVF,
    output logic [2:0]  PIPFAIL
);
    state_t r_state;
    axis_t  r_axis, r_last, w_c0, w_c1, w_sel;
    logic [2:0] w_p, w_m, w_nz, w_neg, w_ovf, w_fail, w_ack_p, w_ack_m;
    logic w_ack;
    assign w_p     = {PIPAZp, PIPAYp, PIPAXp};
    assign w_m     = {PIPAZm, PIPAYm, PIPAXm};
    assign w_ack   = r_state == S_REQ && CTRACK;
    assign w_ack_p = (w_ack && !CTRMINC) ? 3'b001 << r_axis : 3'b000;
    assign w_ack_m = (w_ack && CTRMINC) ? 3'b001 << r_axis : 3'b000;
    assign w_c0    = nxt_axis(r_last);
    assign w_c1    = nxt_axis(w_c0);
    assign w_sel   = w_nz[w_c0] ? w_c0 : w_nz[w_c1] ? w_c1 : r_last;
    for (genvar i = 0; i < 3; i++) begin : g_ax
        pipa_axis_acc #(.PW(PW)) u_acc (
            .clk        (CLOCK),
            .rst        (rst),
            .i_sam      (PIPSAM),
            .i_p        (w_p[i]),
            .i_m        (w_m[i]),
            .i_ack_p    (w_ack_p[i]),
            .i_ack_m    (w_ack_m[i]),
            .o_pend_nz  (w_nz[i]),
            .o_pend_neg (w_neg[i]),
            .o_ovf_evt  (w_ovf[i]),
            .o_fail_evt (w_fail[i])
        );
    end
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_axis  <= AX_X;
            r_last  <= AX_Z;
            CTRREQ  <= 1'b0;
            CTRADR  <= '0;
            CTRMINC <= 1'b0;
            PIPOVF  <= 1'b0;
            PIPFAIL <= '0;
        end else begin
            PIPOVF  <= |w_ovf | (PIPOVF & ~CLRFLG);
            PIPFAIL <= w_fail | (PIPFAIL & {3{~CLRFLG}});
            case (r_state)
                S_IDLE: if (|w_nz) begin
                    r_axis  <= w_sel;
                    CTRADR  <= axis_adr(w_sel);
                    CTRMINC <= w_neg[w_sel];
                    CTRREQ  <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: if (CTRACK) begin
                    CTRREQ  <= 1'b0;
                    r_last  <= r_axis;
                    r_state <= S_GAP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipa_incr_sched.sv
// tb_pipa_incr_sched: directed stimulus checked every cycle against a behavioural scheduler model
module tb_pipa_incr_sched;
    localparam int PW  = 4;
    localparam int LIM = 2**(PW-1)-1;
    logic CLOCK, rst, PIPSAM, CTRACK, CLRFLG;
    logic PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
    logic CTRREQ, CTRMINC, PIPOVF;
    logic [11:0] CTRADR;
    logic [2:0] PIPFAIL;
    int n_tests = 0;
    int n_fail = 0;

    pipa_incr_sched #(.PW(PW)) dut (
        .CLOCK(CLOCK), .rst(rst), .PIPSAM(PIPSAM),
        .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp),
        .PIPAYm(PIPAYm), .PIPAZp(PIPAZp), .PIPAZm(PIPAZm),
        .CTRACK(CTRACK), .CLRFLG(CLRFLG), .CTRREQ(CTRREQ),
        .CTRADR(CTRADR), .CTRMINC(CTRMINC), .PIPOVF(PIPOVF),
        .PIPFAIL(PIPFAIL)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: pending counts as plain integers, a phase number and last-granted index.
    int m_pend[3];
    int m_phase, m_axis, m_last;
    bit m_req, m_minc, m_ovf, m_valid;
    bit [2:0] m_fail;
    int m_adr;
    always @(posedge CLOCK) begin : mdl
        int n, net, a;
        int np[3];
        bit ack, ovf, found;
        bit [2:0] p, m;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
            m_phase = 0; m_last = 2; m_axis = 0;
            m_req = 0; m_minc = 0; m_adr = 0; m_ovf = 0; m_fail = 0;
        end else begin
            p = {PIPAZp, PIPAYp, PIPAXp};
            m = {PIPAZm, PIPAYm, PIPAXm};
            ack = m_phase == 1 && CTRACK;
            ovf = 0;
            for (int i = 0; i < 3; i++) begin
                net = !PIPSAM ? 0 : (p[i] && !m[i]) ? 1 : (m[i] && !p[i]) ? -1 : 0;
                n = m_pend[i] + net;
                if (ack && m_axis == i) n = m_minc ? n + 1 : n - 1;
                if (n > LIM) begin n = LIM; ovf = 1; end
                if (n < -LIM) begin n = -LIM; ovf = 1; end
                np[i] = n;
                m_fail[i] = (PIPSAM && p[i] && m[i]) ? 1'b1 : CLRFLG ? 1'b0 : m_fail[i];
            end
            m_ovf = ovf ? 1'b1 : CLRFLG ? 1'b0 : m_ovf;
            if (m_phase == 0) begin
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    a = (m_last + k) % 3;
                    if (!found && m_pend[a] != 0) begin
                        found = 1; m_axis = a; m_minc = m_pend[a] < 0;
                        m_adr = 31 + a; m_req = 1; m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (CTRACK) begin m_req = 0; m_last = m_axis; m_phase = 2; end
            end else m_phase = 0;
            for (int i = 0; i < 3; i++) m_pend[i] = np[i];
        end
        m_valid = 1;
    end

    always @(negedge CLOCK) if (m_valid) begin
        chk("req", CTRREQ, m_req);
        if (m_req) begin
            chk("adr", CTRADR, m_adr);
            chk("minc", CTRMINC, m_minc);
        end
        chk("ovf", PIPOVF, m_ovf);
        chk("fail", PIPFAIL, m_fail);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic set_lines(input logic [5:0] v);
        {PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm} = v;
    endtask

    task automatic sample(input logic [5:0] v);
        set_lines(v); PIPSAM = 1'b1;
        cyc(1);
        set_lines(6'b0); PIPSAM = 1'b0;
    endtask

    task automatic ack();
        CTRACK = 1'b1;
        cyc(1);
        CTRACK = 1'b0;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (CTRREQ !== 1'b1 && waited < 20) begin
            cyc(1);
            waited++;
        end
        chk("req_seen", CTRREQ, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    logic [11:0] rr_adr [3];
    logic        rr_minc [3];
    int w;
    initial begin
        rr_adr = '{12'o0037, 12'o0040, 12'o0041};
        rr_minc = '{1'b0, 1'b1, 1'b0};
        rst = 1'b1; PIPSAM = 1'b0; CTRACK = 1'b0; CLRFLG = 1'b0;
        set_lines(6'b0);
        // reset with toggling sample/pulse inputs
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            PIPSAM = ~PIPSAM;
            set_lines(6'($urandom));
        end
        cyc(1);
        rst = 1'b0; PIPSAM = 1'b0; set_lines(6'b0);
        cyc(1);
        chk("rst_req", CTRREQ, 0);
        chk("rst_adr", CTRADR, 0);
        chk("rst_minc", CTRMINC, 0);
        chk("rst_ovf", PIPOVF, 0);
        chk("rst_fail", PIPFAIL, 0);
        cyc(3);
        chk("rst_noreq", CTRREQ, 0);

        // round robin X+, Y-, Z+ from reset: X first, then Y, then Z
        sample(6'b100110);
        for (int i = 0; i < 3; i++) begin
            wait_req(w);
            chk("rr_wait", w, i == 0 ? 1 : 2);
            chk("rr_adr", CTRADR, rr_adr[i]);
            chk("rr_minc", CTRMINC, rr_minc[i]);
            ack();
        end
        cyc(4);
        chk("rr_done", CTRREQ, 0);

        // single Y+ pulse held 5 cycles
        sample(6'b001000);
        chk("y_lat0", CTRREQ, 0);
        cyc(1);
        chk("y_req", CTRREQ, 1);
        chk("y_adr", CTRADR, 12'o0040);
        chk("y_minc", CTRMINC, 0);
        cyc(4);
        chk("y_hold", CTRREQ, 1);
        ack();
        chk("y_gap", CTRREQ, 0);
        cyc(2);
        chk("y_idle", CTRREQ, 0);

        // sign change while request held
        sample(6'b100000);
        wait_req(w);
        chk("sc_adr", CTRADR, 12'o0037);
        chk("sc_minc", CTRMINC, 0);
        sample(6'b010000);
        chk("sc_pend0", m_pend[0], 0);
        ack();
        chk("sc_pendm1", m_pend[0], -1);
        wait_req(w);
        chk("sc_adr2", CTRADR, 12'o0037);
        chk("sc_minc2", CTRMINC, 1);
        ack();

        // saturation on Z, fail on X, flag clearing
        cyc(3);
        repeat (9) sample(6'b000010);
        chk("sat_ovf", PIPOVF, 1);
        chk("sat_pend", m_pend[2], LIM);
        chk("sat_adr", CTRADR, 12'o0041);
        sample(6'b110000);
        chk("fail_x", PIPFAIL, 3'b001);
        chk("fail_pend", m_pend[0], 0);
        CLRFLG = 1'b1;
        cyc(1);
        CLRFLG = 1'b0;
        chk("clr_ovf", PIPOVF, 0);
        chk("clr_fail", PIPFAIL, 0);
        CLRFLG = 1'b1;
        sample(6'b110000);
        CLRFLG = 1'b0;
        chk("setwins", PIPFAIL, 3'b001);
        CLRFLG = 1'b1;
        cyc(1);
        CLRFLG = 1'b0;
        repeat (LIM) begin
            wait_req(w);
            chk("drain_adr", CTRADR, 12'o0041);
            ack();
        end
        cyc(6);
        chk("drain_noreq", CTRREQ, 0);

        // reset while a request is held
        repeat (3) sample(6'b100000);
        chk("mr_req", CTRREQ, 1);
        chk("mr_adr", CTRADR, 12'o0037);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mr_drop", CTRREQ, 0);
        CTRACK = 1'b1;
        cyc(1);
        CTRACK = 1'b0;
        cyc(5);
        chk("mr_noreq", CTRREQ, 0);
        chk("mr_pend", m_pend[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
